clkdiv_sequencer: RTL
=====================

Name: clkdiv_sequencer

Overview:
Run-time controller for a divided clock. It generates a 50%-duty `clkout` from `clk` and lets software start and stop it without glitches. The divisor is programmed through a valid/ready handshake and applied only at a phase boundary. It replaces fixed-divisor dividers wherever the rate must change in the field, for example LED blink rates or serial bit clocks.

Parameters:
- `DIV_W`, default 32: width of the divisor (half-period length in `clk` cycles).
- `DEFAULT_DIV`, default 1: divisor loaded at reset. Must be ≥1.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level, sampled each cycle. Requests the output clock to run.
- `stop`, input, 1: level, sampled each cycle. Requests a clean stop.
- `div_valid`, input, 1: a new divisor is offered.
- `div_data`, input, `DIV_W`: new half-period in `clk` cycles. A value of 0 is coerced to 1.
- `div_ready`, output, 1: block can accept a divisor.
- `clkout`, output, 1: divided clock, registered.
- `rise_tick`, output, 1: one-cycle pulse, high in the cycle `clkout` is first 1.
- `fall_tick`, output, 1: one-cycle pulse, high in the cycle `clkout` is first 0 after a high phase.
- `running`, output, 1: 1 in RUN and STOPPING states.
- `active_div`, output, `DIV_W`: divisor currently in use.

Behaviour:
- **Reset** (async, `reset_n`=0):
  - state IDLE; counter 0; `clkout`=0; both ticks 0; `running`=0.
  - `active_div`=`DEFAULT_DIV`; pending flag 0; `div_ready`=1.
  - A reset mid-operation discards any pending divisor.
- **States:** IDLE, RUN, STOPPING.
- **IDLE:**
  - counter held at 0, `clkout`=0.
  - `start`=1 and `stop`=0 → RUN next cycle, counter starting at 0.
  - `start` and `stop` both 1 → stop wins; remain IDLE.
- **RUN:**
  - counter increments each cycle.
  - When counter==`active_div`-1: counter←0, `clkout` toggles, and the matching tick pulses in the same cycle `clkout` changes.
  - Period is 2×`active_div` cycles. First `clkout` rise is `active_div` cycles after entering RUN.
  - `start` is ignored.
- **Stop from RUN:**
  - `clkout`=0 when `stop` is sampled → IDLE next cycle. Counter←0, no tick; the low phase is truncated (the output stays low, so there is no glitch).
  - `clkout`=1 → STOPPING. The high phase completes normally; at its terminal count `clkout` falls, `fall_tick` pulses, and the state goes to IDLE.
  - `start` and `stop` are ignored in STOPPING.
- **Divisor handshake:**
  - Transfer occurs when `div_valid`&&`div_ready`. `div_data`==0 is stored as 1.
  - In IDLE: `active_div` is updated the next cycle and `div_ready` stays 1.
  - In RUN/STOPPING: the value is stored as pending and `div_ready`←0.
  - The pending value is applied (`active_div` updated, `div_ready`←1) at the next boundary, whichever comes first:
    - the cycle `clkout` falls (high→low terminal count), or
    - entry to IDLE via a low-phase stop.
  - A new divisor therefore always begins at the start of a low phase. The current high phase uses the old divisor.
  - `div_valid` is ignored while `div_ready`=0. There is never more than one pending value.
- **Width rules:**
  - Counter width is `DIV_W`. Compare against `active_div`-1 in `DIV_W` bits; since `active_div` ≥1, there is no underflow.
  - Maximum half-period is 2^`DIV_W`-1 cycles. The counter never wraps past `active_div`-1.
- **Latency:** `start` to `running`=1 is 1 cycle. Ticks are combinational in neither direction: they are registered and coincident with the `clkout` edge.

Test Plan:
- **Reset defaults:** assert `reset_n`=0 mid-RUN with `clkout`=1 → `clkout`=0, `running`=0, `div_ready`=1 and `active_div`=`DEFAULT_DIV` immediately (asynchronously). Release → remains IDLE until `start`.
- **Basic run:** in IDLE write div 3, pulse `start` → `running`=1 after 1 cycle; first rise 3 cycles later; thereafter 3 high, 3 low. `rise_tick`/`fall_tick` each pulse once per 6-cycle period.
- **Divisor change:** while running at div 3, write 5 during the high phase → `div_ready`=0 until the fall edge. High phase stays 3 cycles; the subsequent low/high phases are 5 cycles each. `active_div` changes 3→5 in the fall cycle.
- **Clean stop:**
  - `stop` during the 2nd high cycle of div 4 → `clkout` stays high 2 more cycles, falls with `fall_tick`, then IDLE and `running`=0.
  - `stop` during the low phase → IDLE next cycle with `clkout`=0 and no ticks.
- **Zero and priority:**
  - write div 0 → `active_div`=1, `clkout` toggles every cycle (period 2).
  - assert `start` and `stop` together in IDLE → stays IDLE.
- **Pending plus stop:** in RUN with `clkout`=0, write div 7 and assert `stop` in the same cycle → IDLE next cycle with `active_div`=7 and `div_ready`=1.

Source files
------------

// File: rtl/clkdiv_sequencer_if.sv
// Divisor programming channel: valid/ready handshake carrying a new half-period.
interface clkdiv_sequencer_if #(
  parameter int DIV_W = 32
);
  logic             div_valid;
  logic [DIV_W-1:0] div_data;
  logic             div_ready;

  modport master (output div_valid, output div_data, input div_ready);
  modport slave  (input div_valid, input div_data, output div_ready);
endinterface

// File: rtl/clkdiv_sequencer.sv
// Run-time programmable 50%-duty clock divider with glitch-free start/stop.
// The divisor (half-period in clk cycles) is only ever switched at the start
// of a low phase, so every emitted high phase is complete and uses one divisor.
module clkdiv_sequencer #(
  parameter int DIV_W       = 32,
  parameter int DEFAULT_DIV = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  clkdiv_sequencer_if.slave div,
  output logic              clkout,
  output logic              rise_tick,
  output logic              fall_tick,
  output logic              running,
  output logic [DIV_W-1:0]  active_div
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]       state, nxt_state;
  logic [DIV_W-1:0] cnt, nxt_cnt;
  logic             nxt_clk, nxt_rise, nxt_fall;
  logic             boundary;   // a low phase begins (or we park in IDLE) next cycle
  logic             pend;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] new_div;
  logic             xfer;
  logic             tc;

  // Handshake: only one value may be outstanding, so ready is simply !pend.
  assign div.div_ready = !pend;
  assign xfer          = div.div_valid && !pend;
  assign new_div       = (div.div_data == '0) ? DIV_W'(1) : div.div_data;
  // active_div >= 1 always, so the subtraction cannot underflow.
  assign tc            = (cnt == active_div - DIV_W'(1));
  assign running       = (state != S_IDLE);

  // Next-state, counter and clock-edge decode.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_clk   = clkout;
    nxt_rise  = 1'b0;
    nxt_fall  = 1'b0;
    boundary  = 1'b0;
    case (state)
      S_IDLE: begin
        nxt_cnt = '0;
        nxt_clk = 1'b0;
        if (start && !stop) nxt_state = S_RUN;
      end
      S_RUN: begin
        if (stop && !clkout) begin
          // Truncate the low phase; output is already low so no glitch.
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          boundary  = 1'b1;
        end else if (tc) begin
          nxt_cnt  = '0;
          nxt_clk  = !clkout;
          nxt_rise = !clkout;
          nxt_fall = clkout;
          boundary = clkout;
          // Stop seen on the last high cycle: the phase is complete, park now.
          if (stop) nxt_state = S_IDLE;
        end else begin
          nxt_cnt = cnt + DIV_W'(1);
          if (stop) nxt_state = clkout ? S_STOP : S_IDLE;
        end
      end
      S_STOP: begin
        if (tc) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          nxt_clk   = 1'b0;
          nxt_fall  = 1'b1;
          boundary  = 1'b1;
        end else begin
          nxt_cnt = cnt + DIV_W'(1);
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
        nxt_clk   = 1'b0;
      end
    endcase
  end

  // Sequencer state, counter, registered clock and edge ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      clkout    <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      clkout    <= nxt_clk;
      rise_tick <= nxt_rise;
      fall_tick <= nxt_fall;
    end
  end

  // Divisor staging: immediate in IDLE or at a boundary, otherwise held pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_div <= DIV_W'(DEFAULT_DIV);
      pend       <= 1'b0;
      pend_div   <= '0;
    end else if (boundary) begin
      if (pend) begin
        active_div <= pend_div;
        pend       <= 1'b0;
      end else if (xfer) begin
        active_div <= new_div;
      end
    end else if (xfer) begin
      if (state == S_IDLE) begin
        active_div <= new_div;
      end else begin
        pend     <= 1'b1;
        pend_div <= new_div;
      end
    end
  end

endmodule
